// File: rtl/seq_alu_pkg.sv
// Shared ALU opcodes, flag bit positions and sequencer state encoding for seq_alu.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    FnA    = 5'd0,
    FnB    = 5'd1,
    FnADD  = 5'd2,
    FnADC  = 5'd3,
    FnSUB  = 5'd4,
    FnSUC  = 5'd5,
    FnNEG  = 5'd6,
    FnAND  = 5'd7,
    FnOR   = 5'd8,
    FnXOR  = 5'd9,
    FnNOT  = 5'd10,
    FnNAND = 5'd11,
    FnNOR  = 5'd12,
    FnLUI  = 5'd13,
    FnLLI  = 5'd14,
    FnLSL  = 5'd15,
    FnLSR  = 5'd16,
    FnASR  = 5'd17,
    FnMUL  = 5'd18
  } alu_functions_t;

  // Bit positions inside the 4-bit Flags vector
  localparam int FLAGS_Z = 0;
  localparam int FLAGS_C = 1;
  localparam int FLAGS_V = 2;
  localparam int FLAGS_N = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } seq_alu_state_t;

  // True for the three codes that walk through the SHIFT state bit by bit
  function automatic logic is_shift(input logic [4:0] f);
    return (f == FnLSL) || (f == FnLSR) || (f == FnASR);
  endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// Combinational WIDTH+1-bit adder with carry-in; sum, carry-out and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_addsub
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] full;

  // Overflow: operands share a sign and the result sign differs from it
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum  = full[WIDTH-1:0];
    cout = full[WIDTH];
    ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with Start/Busy/Done handshake, bit-serial shifter, registered Z/C/V/N flags.
// Latency: Start edge t -> Done at t+2 (non-shift), t+2+k (shift by k), t+2+WIDTH (FnMUL).
// Backpressure: Start is sampled only while idle; Start during Busy is dropped. Optional FnMUL via SEQ_ALU_MUL_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [4:0]       AluFunc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FlagsEn,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal
);

  seq_alu_state_t state, nstate;

  // Operands captured with Start
  logic [4:0]       func_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             fen_q, cin_q;

  // Working result and pending flag updates
  logic [WIDTH-1:0] work_q;
  logic             cw_q, vw_q, updc_q, updv_q, ill_q;
  logic [SHW:0]     cnt_q;

  // Architectural outputs
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q, illegal_q;

  // Adder hookup
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_c, add_v;

  // EXEC-stage decode results
  logic [WIDTH-1:0] ex_res;
  logic             ex_c, ex_v, ex_updc, ex_updv, ex_ill, ex_iter;
  logic [SHW:0]     ex_cnt;

  // One SHIFT-state iteration
  logic [WIDTH-1:0] sh_res;
  logic             sh_c;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] hi_q, sh_hi;
  logic [WIDTH:0]   mul_sum;
`endif

  assign Result  = result_q;
  assign Flags   = flags_q;
  assign Done    = done_q;
  assign Illegal = illegal_q;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_c),
    .ovf  (add_v)
  );

  // Adder operand selection: subtraction forms feed ~B (or ~A for NEG)
  always_comb begin
    add_a   = a_q;
    add_b   = b_q;
    add_cin = 1'b0;
    case (func_q)
      FnADC: add_cin = cin_q;
      FnSUB: begin add_b = ~b_q; add_cin = 1'b1;  end
      FnSUC: begin add_b = ~b_q; add_cin = cin_q; end
      FnNEG: begin add_a = '0; add_b = ~a_q; add_cin = 1'b1; end
      default: ;
    endcase
  end

  // Single-cycle result for each code, or the seed for an iterative one
  always_comb begin
    ex_res  = '0;
    ex_c    = 1'b0;
    ex_v    = 1'b0;
    ex_updc = 1'b0;
    ex_updv = 1'b0;
    ex_ill  = 1'b0;
    ex_iter = 1'b0;
    ex_cnt  = '0;
    case (func_q)
      FnADD, FnADC, FnSUB, FnSUC, FnNEG: begin
        ex_res  = add_sum;
        ex_c    = add_c;
        ex_v    = add_v;
        ex_updc = 1'b1;
        ex_updv = 1'b1;
      end
      FnA:    ex_res = a_q;
      FnB:    ex_res = b_q;
      FnAND:  ex_res = a_q & b_q;
      FnOR:   ex_res = a_q | b_q;
      FnXOR:  ex_res = a_q ^ b_q;
      FnNOT:  ex_res = ~a_q;
      FnNAND: ex_res = ~(a_q & b_q);
      FnNOR:  ex_res = ~(a_q | b_q);
      FnLUI:  ex_res = {b_q[WIDTH/2-1:0], a_q[WIDTH/2-1:0]};
      FnLLI:  ex_res = {a_q[WIDTH-1:WIDTH/2], b_q[WIDTH/2-1:0]};
      FnLSL, FnLSR, FnASR: begin
        // Shift by zero passes A through and leaves C alone
        ex_res  = a_q;
        ex_updv = 1'b1;
        ex_updc = (b_q[SHW-1:0] != '0);
        ex_iter = (b_q[SHW-1:0] != '0);
        ex_cnt  = {1'b0, b_q[SHW-1:0]};
      end
`ifdef SEQ_ALU_MUL_EN
      FnMUL: begin
        // Low product half starts as the multiplier B
        ex_res  = b_q;
        ex_updc = 1'b1;
        ex_updv = 1'b1;
        ex_iter = 1'b1;
        ex_cnt  = (SHW+1)'(WIDTH);
      end
`endif
      default: ex_ill = 1'b1;
    endcase
  end

  // One bit of shift (or one shift-add multiply step) per SHIFT cycle
  always_comb begin
    sh_res = work_q;
    sh_c   = cw_q;
`ifdef SEQ_ALU_MUL_EN
    sh_hi   = hi_q;
    mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
`endif
    case (func_q)
      FnLSL: begin sh_res = {work_q[WIDTH-2:0], 1'b0};            sh_c = work_q[WIDTH-1]; end
      FnLSR: begin sh_res = {1'b0, work_q[WIDTH-1:1]};            sh_c = work_q[0];       end
      FnASR: begin sh_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; sh_c = work_q[0];       end
`ifdef SEQ_ALU_MUL_EN
      FnMUL: begin
        {sh_hi, sh_res} = {mul_sum, work_q[WIDTH-1:1]};
        sh_c            = |mul_sum[WIDTH:1];
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nstate;
  end

  // Next-state and Busy
  always_comb begin
    nstate = state;
    Busy   = 1'b0;
    case (state)
      IDLE:   if (Start) nstate = EXEC;
      EXEC:   begin Busy = 1'b1; nstate = ex_iter ? SHIFT : FINISH; end
      SHIFT:  begin Busy = 1'b1; if (cnt_q == (SHW+1)'(1)) nstate = FINISH; end
      FINISH: begin Busy = 1'b1; nstate = IDLE; end
      default: nstate = IDLE;
    endcase
  end

  // Capture, compute, iterate and commit; reset drops any in-flight op
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fen_q     <= 1'b0;
      cin_q     <= 1'b0;
      work_q    <= '0;
      cw_q      <= 1'b0;
      vw_q      <= 1'b0;
      updc_q    <= 1'b0;
      updv_q    <= 1'b0;
      ill_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      hi_q      <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          func_q <= AluFunc;
          a_q    <= A;
          b_q    <= B;
          fen_q  <= FlagsEn;
          cin_q  <= flags_q[FLAGS_C];
        end
        EXEC: begin
          work_q <= ex_res;
          cw_q   <= ex_c;
          vw_q   <= ex_v;
          updc_q <= ex_updc;
          updv_q <= ex_updv;
          ill_q  <= ex_ill;
          cnt_q  <= ex_cnt;
`ifdef SEQ_ALU_MUL_EN
          hi_q   <= '0;
`endif
        end
        SHIFT: begin
          work_q <= sh_res;
          cw_q   <= sh_c;
          cnt_q  <= cnt_q - (SHW+1)'(1);
`ifdef SEQ_ALU_MUL_EN
          hi_q   <= sh_hi;
`endif
        end
        FINISH: begin
          done_q    <= 1'b1;
          illegal_q <= ill_q;
          result_q  <= ill_q ? '0 : work_q;
          if (fen_q && !ill_q) begin
            flags_q[FLAGS_Z] <= (work_q == '0);
            flags_q[FLAGS_N] <= work_q[WIDTH-1];
            if (updc_q) flags_q[FLAGS_C] <= cw_q;
            if (updv_q) flags_q[FLAGS_V] <= vw_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed vectors, arithmetic reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: exercises Start-while-Busy and Start-in-Done-cycle.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         Start = 1'b0;
  logic [4:0]   AluFunc = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         FlagsEn = 1'b0;
  logic [W-1:0] Result;
  logic [3:0]   Flags;
  logic         Busy, Done, Illegal;

  seq_alu #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Start   (Start),
    .AluFunc (AluFunc),
    .A       (A),
    .B       (B),
    .FlagsEn (FlagsEn),
    .Result  (Result),
    .Flags   (Flags),
    .Busy    (Busy),
    .Done    (Done),
    .Illegal (Illegal)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // Outstanding expectation: op captured at edge exp_start, Done due at exp_done
  int           exp_start = -1;
  int           exp_done  = -1;
  logic [W-1:0] exp_r = '0;
  logic [3:0]   exp_f = '0;
  logic         exp_ill = 1'b0;
  logic [3:0]   mflags = '0;
  bit           chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: outcome of one operation from operand values and flags at capture
  task automatic model(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic fen, input logic [3:0] fl,
                       output logic [W-1:0] r, output logic [3:0] fo, output logic ill,
                       output int lat);
    logic         c, v, cin;
    logic [W-1:0] a0, x;
    longint       us, ss;
    int           k;
    logic [31:0]  p;
    r = '0; c = fl[1]; v = fl[2]; ill = 1'b0; lat = 2;
    case (f)
      FnADD, FnADC, FnSUB, FnSUC, FnNEG: begin
        a0  = (f == FnNEG) ? '0 : a;
        x   = (f == FnADD || f == FnADC) ? b : ((f == FnNEG) ? ~a : ~b);
        cin = (f == FnADC || f == FnSUC) ? fl[1] : ((f == FnADD) ? 1'b0 : 1'b1);
        us  = longint'(a0) + longint'(x) + longint'(cin);
        ss  = longint'($signed(a0)) + longint'($signed(x)) + longint'(cin);
        r   = us[W-1:0];
        c   = us[W];
        v   = (ss > 32767) || (ss < -32768);
      end
      FnA:    r = a;
      FnB:    r = b;
      FnAND:  r = a & b;
      FnOR:   r = a | b;
      FnXOR:  r = a ^ b;
      FnNOT:  r = ~a;
      FnNAND: r = ~(a & b);
      FnNOR:  r = ~(a | b);
      FnLUI:  r = {b[7:0], a[7:0]};
      FnLLI:  r = {a[15:8], b[7:0]};
      FnLSL, FnLSR, FnASR: begin
        k   = int'(b[3:0]);
        lat = 2 + k;
        v   = 1'b0;
        if (k == 0) r = a;
        else if (f == FnLSL) begin r = a << k; c = a[W-k]; end
        else if (f == FnLSR) begin r = a >> k; c = a[k-1]; end
        else begin r = $signed(a) >>> k; c = a[k-1]; end
      end
`ifdef SEQ_ALU_MUL_EN
      FnMUL: begin
        p   = 32'(a) * 32'(b);
        r   = p[15:0];
        c   = |p[31:16];
        v   = 1'b0;
        lat = 2 + W;
      end
`endif
      default: ill = 1'b1;
    endcase
    if (ill) begin
      r  = '0;
      fo = fl;
    end else if (fen) begin
      fo = {r[W-1], v, c, (r == '0)};
    end else begin
      fo = fl;
    end
  endtask

  // Present one op for exactly one edge and record what it must produce
  task automatic issue(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic fen);
    int lat;
    @(negedge Clock);
    AluFunc = f; A = a; B = b; FlagsEn = fen; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    model(f, a, b, fen, mflags, exp_r, exp_f, exp_ill, lat);
    mflags    = exp_f;
    exp_start = cyc;
    exp_done  = cyc + lat;
  endtask

  // Park in the Done cycle the model predicts
  task automatic wait_done();
    repeat (exp_done - cyc) @(posedge Clock);
    #1;
  endtask

  // Hand-stated latency: Done low one cycle before, high at exactly n cycles after capture
  task automatic wait_lit(input int n);
    repeat (exp_start + n - 1 - cyc) @(posedge Clock);
    #1;
    chk("done_early", Done, 1'b0);
    @(posedge Clock); #1;
    chk("done_at_latency", Done, 1'b1);
  endtask

  task automatic op(input logic [4:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic fen);
    issue(f, a, b, fen);
    wait_done();
  endtask

  // Per-cycle comparison of handshake and committed outputs against the model
  always @(negedge Clock) begin
    logic busy_e, done_e;
    if (chk_en) begin
      done_e = (exp_done >= 0) && (cyc == exp_done);
      busy_e = (exp_done >= 0) && (cyc >= exp_start) && (cyc < exp_done);
      chk("busy", Busy, busy_e);
      chk("done", Done, done_e);
      if (done_e) begin
        chk("result", Result, exp_r);
        chk("flags", Flags, exp_f);
        chk("illegal", Illegal, exp_ill);
      end else begin
        chk("illegal_quiet", Illegal, 1'b0);
      end
    end
  end

  initial begin
    #1;
    chk("rst_result", Result, 16'h0000);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_illegal", Illegal, 1'b0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    chk_en = 1'b1;

    // Signed overflow into the sign bit
    issue(FnADD, 16'h7FFF, 16'h0001, 1'b1);
    wait_lit(2);
    chk("add_result", Result, 16'h8000);
    chk("add_flags", Flags, 4'b1100);

    op(FnSUB, 16'd5, 16'd5, 1'b1);
    chk("sub_result", Result, 16'h0000);
    chk("sub_flags", Flags, 4'b0011);

    // Carry-in from the previous SUB
    op(FnSUC, 16'h0000, 16'h0000, 1'b1);
    chk("suc_result", Result, 16'h0000);
    chk("suc_flags", Flags, 4'b0011);

    issue(FnLSL, 16'h8001, 16'd4, 1'b1);
    wait_lit(6);
    chk("lsl_result", Result, 16'h0010);
    chk("lsl_flags", Flags, 4'b0000);

    issue(FnASR, 16'h8000, 16'd15, 1'b1);
    wait_lit(17);
    chk("asr_result", Result, 16'hFFFF);
    chk("asr_flags", Flags, 4'b1000);

    // Zero-amount shift keeps C from the SUB
    op(FnSUB, 16'd5, 16'd5, 1'b1);
    issue(FnLSL, 16'h1234, 16'd0, 1'b1);
    wait_lit(2);
    chk("lsl0_result", Result, 16'h1234);
    chk("lsl0_flags", Flags, 4'b0010);

    op(5'd31, 16'h1234, 16'h5678, 1'b1);
    chk("illegal_pulse", Illegal, 1'b1);
    chk("illegal_result", Result, 16'h0000);
    chk("illegal_flags", Flags, 4'b0010);

    op(FnADC, 16'h00FF, 16'h0001, 1'b1);
    chk("adc_result", Result, 16'h0101);
    op(FnNEG, 16'h8000, 16'h0000, 1'b1);
    op(FnAND, 16'hF0F0, 16'hFF00, 1'b1);
    op(FnOR,  16'h0F0F, 16'h00F0, 1'b1);
    op(FnXOR, 16'hFFFF, 16'hFFFF, 1'b1);
    op(FnNOT, 16'h00FF, 16'h0000, 1'b1);
    op(FnNAND, 16'hFFFF, 16'h0F0F, 1'b1);
    op(FnNOR, 16'h0000, 16'h0000, 1'b1);
    op(FnA, 16'hABCD, 16'h1234, 1'b1);
    op(FnB, 16'hABCD, 16'h0000, 1'b1);
    op(FnLUI, 16'h1234, 16'h5678, 1'b1);
    chk("lui_result", Result, 16'h7834);
    op(FnLLI, 16'h1234, 16'h5678, 1'b1);
    chk("lli_result", Result, 16'h1278);
    op(FnLSR, 16'h8001, 16'd1, 1'b1);
    op(FnASR, 16'h4000, 16'd3, 1'b1);
    op(FnADD, 16'hFFFF, 16'h0001, 1'b0);
    op(FnSUC, 16'h8000, 16'h0001, 1'b1);
    op(FnSUB, 16'h0003, 16'h0007, 1'b1);

    // Start pulses while busy must be dropped
    issue(FnLSL, 16'h0003, 16'd15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge Clock);
      Start = 1'b1; AluFunc = FnADD; A = 16'h1111; B = 16'h2222;
      @(negedge Clock);
      Start = 1'b0;
    end
    wait_lit(17);
    chk("busy_shift_result", Result, 16'h8000);
    chk("busy_shift_flags", Flags, 4'b1010);
    // Accepted in the Done cycle
    issue(FnADD, 16'd2, 16'd3, 1'b1);
    wait_lit(2);
    chk("b2b_result", Result, 16'h0005);

`ifdef SEQ_ALU_MUL_EN
    issue(FnMUL, 16'h0100, 16'h0100, 1'b1);
    wait_lit(18);
    chk("mul_result", Result, 16'h0000);
    chk("mul_flags", Flags, 4'b0011);
    op(FnMUL, 16'h00FF, 16'h0003, 1'b1);
`else
    issue(FnMUL, 16'h0100, 16'h0100, 1'b1);
    wait_lit(2);
    chk("mul_illegal", Illegal, 1'b1);
`endif

    // Reset in the middle of a long shift
    op(FnADD, 16'h7FFF, 16'h0001, 1'b1);
    issue(FnLSL, 16'h0001, 16'd15, 1'b1);
    repeat (5) @(posedge Clock);
    @(negedge Clock); #2;
    nReset = 1'b0;
    #1;
    chk("midrst_result", Result, 16'h0000);
    chk("midrst_flags", Flags, 4'h0);
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    exp_start = -1;
    exp_done  = -1;
    mflags    = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock); #2;
    nReset = 1'b1;
    repeat (20) @(posedge Clock);
    #1;
    op(FnADD, 16'd2, 16'd3, 1'b1);

    repeat (3) @(posedge Clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 16-bit single-cycle ALU datapath; executes every alu_functions_t code on WIDTH-bit operands.
- Start/Busy/Done handshake.
- Iterative 1-bit-per-cycle shifter replaces the combinational shifter.
- Registered Z/C/V/N flags with carry-in feedback for FnADC/FnSUC.
- Sits between the operand muxes (Op1/Op2 select) and the register-file writeback in the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Start  input  1  launch operation; sampled only in IDLE.
- AluFunc  input  5  alu_functions_t code; captured with Start.
- A  input  WIDTH  operand 1; captured with Start.
- B  input  WIDTH  operand 2; captured with Start.
- FlagsEn  input  1  commit flags at completion; captured with Start.
- Result  output  WIDTH  registered result; held until next completion.
- Flags  output  4  registered flags [Z=0,C=1,V=2,N=3].
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle completion pulse.
- Illegal  output  1  one-cycle pulse with Done for unrecognised AluFunc.

Behaviour:
- Reset (async, nReset low): state IDLE; Result=0, Flags=0, Busy=0, Done=0, Illegal=0. Applies mid-operation; the in-flight op is discarded and nothing is committed.
- FSM states: IDLE, EXEC, SHIFT, FINISH.
- IDLE->EXEC on Start. EXEC->FINISH for non-shift codes, or for a shift with amount 0. EXEC->SHIFT for a shift with amount>0. SHIFT->FINISH when the remaining count reaches 0. FINISH->IDLE unconditionally.
- Busy=1 in EXEC/SHIFT/FINISH. Done and Result/Flags update are registered on the FINISH->IDLE edge.
- Latency: Start at edge t gives Done high in cycle t+2 for non-shift codes; shift by k gives Done at t+2+k.
- Start while Busy: ignored, no queuing. Start in the Done cycle is accepted (state is IDLE).
- Arithmetic is WIDTH+1 bits:
  - FnADD: A+B.
  - FnADC: A+B+C.
  - FnSUB: A+~B+1.
  - FnSUC: A+~B+C.
  - FnNEG: 0+~A+1.
  - C = bit WIDTH (C=1 means no borrow for subtraction).
  - V = signed overflow of the operand MSBs.
- Logic/move codes update Z and N only; C and V are unchanged: FnA, FnB, FnAND, FnOR, FnXOR, FnNOT(~A), FnNAND, FnNOR.
- FnLUI: {B[WIDTH/2-1:0], A[WIDTH/2-1:0]}. FnLLI: {A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}. Both update Z,N only.
- Shifts (FnLSL/FnLSR/FnASR): 1 bit per SHIFT cycle, amount = B[SHW-1:0].
  - C = last bit shifted out; unchanged when amount=0.
  - V cleared. ASR replicates the MSB.
- Z = (Result==0); N = Result[WIDTH-1] for all legal codes.
- Flags are written only if the captured FlagsEn=1. Result is always written.
- Carry-in for ADC/SUC is the Flags C value at Start capture.
- Unrecognised code: Result=0, Flags unchanged, Illegal=1 with Done, non-shift latency.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: adds code FnMUL (value 18). Shift-add multiply, 1 bit per cycle through the SHIFT state, WIDTH iterations. Result = low WIDTH bits of A*B (unsigned). Z,N updated; C = OR of the discarded high product bits; V cleared.
- Undefined: FnMUL is treated as an unrecognised code (Illegal pulse).

Decomposition:
- Shared package opcodes: alu_functions_t gains FnMUL=5'd18. FLAGS_Z/C/V/N indices stay there. Add a seq_alu_state_t enum {IDLE, EXEC, SHIFT, FINISH}.
- One sub-module, alu_addsub: combinational WIDTH+1 adder with carry-in, producing sum, C and V. Shared by ADD/ADC/SUB/SUC/NEG.

Test Plan (WIDTH=16):
- Reset, then FnADD A=16'h7FFF B=16'h0001 FlagsEn=1 -> Done at t+2, Result=16'h8000, Flags N=1 V=1 C=0 Z=0.
- FnSUB A=5 B=5, then FnSUC A=16'h0000 B=16'h0000 with C=1 -> Result 0 with Z=1 C=1; then 16'h0000 with Z=1 C=1.
- FnLSL A=16'h8001 B=4 -> Done at t+6, Result=16'h0010, C=0; FnASR A=16'h8000 B=15 -> Result=16'hFFFF, N=1; shift B=0 -> Done at t+2, C unchanged.
- Start pulsed during a 15-cycle shift -> ignored; a single Done; next Start in the Done cycle is accepted.
- nReset asserted mid-SHIFT -> Result=0, Flags=0, Busy=0 immediately; no Done after release.
- AluFunc=5'd31 -> Done+Illegal together, Result=0, Flags unchanged. With SEQ_ALU_MUL_EN: FnMUL 16'h0100*16'h0100 -> Result 0, Z=1, C=1, Done at t+18.
